// File: rtl/jk_cmd_arbiter.sv
// jk_cmd_arbiter: round-robin arbitration of JK commands onto a shared bank of storage bits
module jk_cmd_arbiter #(
    parameter int N_REQ         = 4,
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [2*N_REQ-1:0]     req_cmd,
    input  logic [WIDTH*N_REQ-1:0] req_mask,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       ack,
    output logic                   busy,
    output logic [WIDTH-1:0]       q
);
    localparam int PW = $clog2(N_REQ);
    typedef enum logic [1:0] {IDLE, APPLY, SETTLE} state_t;
    state_t           state, state_n;
    logic [PW-1:0]    rr_ptr, win;
    logic [1:0]       cmd_r;
    logic [WIDTH-1:0] mask_r, q_n;
    logic [3:0]       settle_cnt;
    logic             found;
    int               idx;

    // pick the first asserted request at or after rr_ptr, wrapping around
    always_comb begin
        win = '0;
        found = 1'b0;
        idx = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win = PW'(idx);
            end
        end
    end

    // next state, handshake outputs and the JK result of the captured command
    always_comb begin
        state_n = state == IDLE  ? (found ? APPLY : IDLE) :
                  state == APPLY ? ((SETTLE_CYCLES > 0) ? SETTLE : IDLE) :
                  (settle_cnt == 4'd0) ? IDLE : SETTLE;
        ack = (state == APPLY) ? grant : '0;
        busy = state != IDLE;
        q_n = cmd_r == 2'b01 ? q & ~mask_r :
              cmd_r == 2'b10 ? q | mask_r :
              cmd_r == 2'b11 ? q ^ mask_r : q;
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // capture the winner at grant, commit q on the APPLY edge, count out the settle window
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant      <= '0;
            cmd_r      <= '0;
            mask_r     <= '0;
            rr_ptr     <= '0;
            settle_cnt <= '0;
            q          <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    grant  <= N_REQ'(1) << win;
                    cmd_r  <= req_cmd[2*int'(win) +: 2];
                    mask_r <= req_mask[WIDTH*int'(win) +: WIDTH];
                    rr_ptr <= (int'(win) == N_REQ-1) ? '0 : win + 1'b1;
                end
                APPLY: begin
                    q          <= q_n;
                    settle_cnt <= 4'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES-1 : 0);
                    grant      <= (SETTLE_CYCLES > 0) ? grant : '0;
                end
                SETTLE: begin
                    settle_cnt <= (settle_cnt == 4'd0) ? 4'd0 : settle_cnt - 4'd1;
                    grant      <= (settle_cnt == 4'd0) ? '0 : grant;
                end
                default: ;
            endcase
        end
    end
endmodule
